cpu_int_ctrl: RTL and testbench

- Parametrised interrupt controller for the cpu_6502 core, sitting between the console interrupt sources (PPU NMI, APU/mapper IRQs) and the CPU microcode sequencer.
- Provides NMI falling-edge capture, N_IRQ active-low IRQ channels (level or edge mode per channel) with fixed priority, BRK/NMI hijack resolution, reset-sequence vectoring, and correct hold behaviour during DMA pause.
- Supplies the sequencer with the vector addresses, the B-flag value to push, and the serviced channel ID.

---
 rtl/cpu_int_ctrl_if.sv | 40 ++++
 rtl/cpu_int_ctrl.sv | 156 +++++++++++++++
 tb/tb_cpu_int_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_int_ctrl_if.sv
// Interrupt controller <-> sequencer/source bundle; slave = controller, master = sequencer + sources.
// No pipelining inside the interface.
// No backpressure: strobes are single-cycle, gated only by the controller's pause input.
interface cpu_int_ctrl_if #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = 2
);
    logic             i_PAUSE;
    logic             i_NMI_N;
    logic [N_IRQ-1:0] i_IRQ_N;
    logic [N_IRQ-1:0] i_IRQ_CLR;
    logic             i_I_FLAG;
    logic             i_POLL;
    logic             i_BRK;
    logic             i_VEC_LATCH;
    logic             i_INT_DONE;
    logic             o_INT_REQ;
    logic             o_RST_SEQ;
    logic [15:0]      o_VEC_L;
    logic [15:0]      o_VEC_H;
    logic             o_IS_NMI;
    logic             o_B_FLAG;
    logic [N_IRQ-1:0] o_IRQ_PEND;
    logic [ID_W-1:0]  o_IRQ_ID;
    logic             o_ID_VALID;

    modport slave (
        input  i_PAUSE, i_NMI_N, i_IRQ_N, i_IRQ_CLR, i_I_FLAG,
               i_POLL, i_BRK, i_VEC_LATCH, i_INT_DONE,
        output o_INT_REQ, o_RST_SEQ, o_VEC_L, o_VEC_H, o_IS_NMI,
               o_B_FLAG, o_IRQ_PEND, o_IRQ_ID, o_ID_VALID
    );

    modport master (
        output i_PAUSE, i_NMI_N, i_IRQ_N, i_IRQ_CLR, i_I_FLAG,
               i_POLL, i_BRK, i_VEC_LATCH, i_INT_DONE,
        input  o_INT_REQ, o_RST_SEQ, o_VEC_L, o_VEC_H, o_IS_NMI,
               o_B_FLAG, o_IRQ_PEND, o_IRQ_ID, o_ID_VALID
    );
endinterface

// File: rtl/cpu_int_ctrl.sv
// 6502 interrupt controller: NMI edge capture, prioritised IRQs, BRK/NMI hijack, reset vectoring.
// Pendings update one cycle after a line edge; o_INT_REQ and live selection are combinational.
// i_PAUSE freezes state and latched selection; edge detectors keep sampling.
module cpu_int_ctrl #(
    parameter int               N_IRQ     = 4,
    parameter int               ID_W      = 2,
    parameter logic [N_IRQ-1:0] EDGE_MODE = '0,
    parameter logic [15:0]      NMI_VEC   = 16'hFFFA,
    parameter logic [15:0]      RST_VEC   = 16'hFFFC,
    parameter logic [15:0]      IRQ_VEC   = 16'hFFFE
) (
    input  logic          i_CLK,
    input  logic          i_RST_N,
    cpu_int_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_RST, S_IDLE, S_SEQ, S_LATCHED} state_t;

    state_t           state;
    logic             nmi_last;
    logic [N_IRQ-1:0] irq_last;
    logic             nmi_pend;
    logic [N_IRQ-1:0] edge_pend;
    logic             brk;
    logic             lat_nmi;
    logic [ID_W-1:0]  lat_id;
    logic             lat_valid;
    logic [15:0]      lat_vec;

    logic             nmi_edge;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] irq_pend;
    logic             sel_valid;
    logic [ID_W-1:0]  sel_id;
    logic [N_IRQ-1:0] sel_clr;
    logic             latch_fire;
    logic             int_req;
    logic [15:0]      live_vec;
    logic             nmi_pend_nxt;
    logic [N_IRQ-1:0] edge_pend_nxt;

    assign nmi_edge   = nmi_last & ~bus.i_NMI_N;
    assign irq_edge   = irq_last & ~bus.i_IRQ_N;
    assign latch_fire = ~bus.i_PAUSE & (state == S_SEQ) & bus.i_VEC_LATCH;
    assign live_vec   = nmi_pend ? NMI_VEC : IRQ_VEC;
    assign int_req    = (state == S_IDLE) & (nmi_pend | ((|irq_pend) & ~bus.i_I_FLAG));

    // Descending scan so the lowest pending index is the last assignment and wins.
    always_comb begin
        irq_pend  = '0;
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            irq_pend[k] = EDGE_MODE[k] ? edge_pend[k] : ~bus.i_IRQ_N[k];
        end
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (irq_pend[k]) begin
                sel_valid = 1'b1;
                sel_id    = ID_W'(k);
            end
        end
    end

    // A new edge in the same cycle as any clear keeps the pending set.
    always_comb begin
        sel_clr       = '0;
        edge_pend_nxt = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            sel_clr[k]       = latch_fire & ~nmi_pend & sel_valid & (sel_id == ID_W'(k));
            edge_pend_nxt[k] = EDGE_MODE[k] &
                               (irq_edge[k] | (edge_pend[k] & ~bus.i_IRQ_CLR[k] & ~sel_clr[k]));
        end
        nmi_pend_nxt = nmi_edge | (nmi_pend & ~latch_fire);
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= S_RST;
            nmi_last  <= 1'b1;
            irq_last  <= '1;
            nmi_pend  <= 1'b0;
            edge_pend <= '0;
            brk       <= 1'b0;
            lat_nmi   <= 1'b0;
            lat_id    <= '0;
            lat_valid <= 1'b0;
            lat_vec   <= RST_VEC;
        end else begin
            nmi_last  <= bus.i_NMI_N;
            irq_last  <= bus.i_IRQ_N;
            nmi_pend  <= nmi_pend_nxt;
            edge_pend <= edge_pend_nxt;
            if (!bus.i_PAUSE) begin
                case (state)
                    S_RST: begin
                        if (bus.i_INT_DONE) state <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (bus.i_BRK) begin
                            brk   <= 1'b1;
                            state <= S_SEQ;
                        end else if (bus.i_POLL && int_req) begin
                            brk   <= 1'b0;
                            state <= S_SEQ;
                        end
                    end
                    S_SEQ: begin
                        if (bus.i_VEC_LATCH) begin
                            lat_nmi   <= nmi_pend;
                            lat_id    <= nmi_pend ? '0 : sel_id;
                            lat_valid <= ~nmi_pend & sel_valid;
                            lat_vec   <= live_vec;
                            state     <= S_LATCHED;
                        end
                    end
                    S_LATCHED: begin
                        if (bus.i_INT_DONE) state <= S_IDLE;
                    end
                    default: state <= S_RST;
                endcase
            end
        end
    end

    // S_SEQ shows the live selection so a late NMI can still hijack before the vector fetch.
    always_comb begin
        bus.o_VEC_L    = lat_vec;
        bus.o_IS_NMI   = 1'b0;
        bus.o_IRQ_ID   = '0;
        bus.o_ID_VALID = 1'b0;
        bus.o_B_FLAG   = 1'b0;
        case (state)
            S_RST: bus.o_VEC_L = RST_VEC;
            S_SEQ: begin
                bus.o_VEC_L    = live_vec;
                bus.o_IS_NMI   = nmi_pend;
                bus.o_IRQ_ID   = nmi_pend ? '0 : sel_id;
                bus.o_ID_VALID = ~nmi_pend & sel_valid;
                bus.o_B_FLAG   = brk;
            end
            S_LATCHED: begin
                bus.o_IS_NMI   = lat_nmi;
                bus.o_IRQ_ID   = lat_id;
                bus.o_ID_VALID = lat_valid;
                bus.o_B_FLAG   = brk;
            end
            default: ;
        endcase
    end

    assign bus.o_VEC_H    = bus.o_VEC_L + 16'd1;
    assign bus.o_INT_REQ  = int_req;
    assign bus.o_RST_SEQ  = (state == S_RST);
    assign bus.o_IRQ_PEND = irq_pend;

endmodule

// File: tb/tb_cpu_int_ctrl.sv
// Directed bench for cpu_int_ctrl with channel 2 edge-latched, others level.
module tb_cpu_int_ctrl;
    logic i_CLK = 1'b0;
    logic i_RST_N = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 i_CLK = ~i_CLK;

    cpu_int_ctrl_if #(.N_IRQ(4), .ID_W(2)) bus ();

    cpu_int_ctrl #(
        .N_IRQ(4), .ID_W(2), .EDGE_MODE(4'b0100),
        .NMI_VEC(16'hFFFA), .RST_VEC(16'hFFFC), .IRQ_VEC(16'hFFFE)
    ) dut (
        .i_CLK(i_CLK),
        .i_RST_N(i_RST_N),
        .bus(bus)
    );

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.i_PAUSE = 0; bus.i_NMI_N = 1; bus.i_IRQ_N = 4'hF; bus.i_IRQ_CLR = 4'h0;
        bus.i_I_FLAG = 1; bus.i_POLL = 0; bus.i_BRK = 0; bus.i_VEC_LATCH = 0; bus.i_INT_DONE = 0;
        #2;
        chk("rst_rst_seq", 32'(bus.o_RST_SEQ), 32'd1);
        chk("rst_int_req", 32'(bus.o_INT_REQ), 32'd0);
        chk("rst_vec_l", 32'(bus.o_VEC_L), 32'hFFFC);
        chk("rst_vec_h", 32'(bus.o_VEC_H), 32'hFFFD);
        chk("rst_is_nmi", 32'(bus.o_IS_NMI), 32'd0);
        chk("rst_b_flag", 32'(bus.o_B_FLAG), 32'd0);
        chk("rst_pend", 32'(bus.o_IRQ_PEND), 32'd0);
        chk("rst_id", 32'(bus.o_IRQ_ID), 32'd0);
        chk("rst_id_valid", 32'(bus.o_ID_VALID), 32'd0);
        tick(); tick();
        i_RST_N = 1;
        tick();
        chk("rst_seq_held", 32'(bus.o_RST_SEQ), 32'd1);
        bus.i_INT_DONE = 1; #1;
        chk("rst_done_vec_l", 32'(bus.o_VEC_L), 32'hFFFC);
        chk("rst_done_vec_h", 32'(bus.o_VEC_H), 32'hFFFD);
        chk("rst_done_seq", 32'(bus.o_RST_SEQ), 32'd1);
        tick();
        bus.i_INT_DONE = 0; #1;
        chk("idle_rst_seq", 32'(bus.o_RST_SEQ), 32'd0);
        chk("idle_int_req", 32'(bus.o_INT_REQ), 32'd0);

        // NMI with I=1
        bus.i_NMI_N = 0;
        tick(); #1;
        chk("nmi_req", 32'(bus.o_INT_REQ), 32'd1);
        bus.i_POLL = 1; tick(); bus.i_POLL = 0; #1;
        chk("nmi_seq_is_nmi", 32'(bus.o_IS_NMI), 32'd1);
        chk("nmi_seq_vec_l", 32'(bus.o_VEC_L), 32'hFFFA);
        chk("nmi_seq_b", 32'(bus.o_B_FLAG), 32'd0);
        bus.i_VEC_LATCH = 1; tick(); bus.i_VEC_LATCH = 0; #1;
        chk("nmi_lat_vec_l", 32'(bus.o_VEC_L), 32'hFFFA);
        chk("nmi_lat_vec_h", 32'(bus.o_VEC_H), 32'hFFFB);
        chk("nmi_lat_is_nmi", 32'(bus.o_IS_NMI), 32'd1);
        bus.i_INT_DONE = 1; tick(); bus.i_INT_DONE = 0; tick(); #1;
        chk("nmi_no_retrigger", 32'(bus.o_INT_REQ), 32'd0);
        bus.i_NMI_N = 1;

        // Level IRQ, channel 1 beats channel 2
        bus.i_I_FLAG = 0; bus.i_IRQ_N = 4'b1001; #1;
        chk("lvl_pend_first", 32'(bus.o_IRQ_PEND), 32'b0010);
        chk("lvl_req", 32'(bus.o_INT_REQ), 32'd1);
        bus.i_POLL = 1; tick(); bus.i_POLL = 0; #1;
        chk("lvl_seq_id", 32'(bus.o_IRQ_ID), 32'd1);
        chk("lvl_seq_valid", 32'(bus.o_ID_VALID), 32'd1);
        chk("lvl_seq_vec_l", 32'(bus.o_VEC_L), 32'hFFFE);
        chk("lvl_seq_is_nmi", 32'(bus.o_IS_NMI), 32'd0);
        chk("lvl_seq_pend", 32'(bus.o_IRQ_PEND), 32'b0110);
        bus.i_VEC_LATCH = 1; tick(); bus.i_VEC_LATCH = 0; #1;
        chk("lvl_lat_id", 32'(bus.o_IRQ_ID), 32'd1);
        chk("lvl_lat_vec_l", 32'(bus.o_VEC_L), 32'hFFFE);
        chk("lvl_lat_pend", 32'(bus.o_IRQ_PEND), 32'b0110);
        bus.i_INT_DONE = 1; tick(); bus.i_INT_DONE = 0; bus.i_I_FLAG = 1; #1;
        chk("lvl_masked_req", 32'(bus.o_INT_REQ), 32'd0);
        bus.i_IRQ_N = 4'hF; #1;
        chk("lvl_release_pend", 32'(bus.o_IRQ_PEND), 32'b0100);
        bus.i_IRQ_CLR = 4'b0100; tick(); bus.i_IRQ_CLR = 0; #1;
        chk("clr_pend", 32'(bus.o_IRQ_PEND), 32'd0);

        // Edge channel 2: one-cycle pulse, then clear vs new edge
        bus.i_IRQ_N = 4'b1011; tick(); bus.i_IRQ_N = 4'hF; #1;
        chk("edge_latched", 32'(bus.o_IRQ_PEND), 32'b0100);
        tick(); tick(); #1;
        chk("edge_persist", 32'(bus.o_IRQ_PEND), 32'b0100);
        bus.i_IRQ_N = 4'b1011; bus.i_IRQ_CLR = 4'b0100; tick();
        bus.i_IRQ_N = 4'hF; bus.i_IRQ_CLR = 0; #1;
        chk("edge_set_wins", 32'(bus.o_IRQ_PEND), 32'b0100);
        bus.i_IRQ_CLR = 4'b0100; tick(); bus.i_IRQ_CLR = 0; #1;
        chk("edge_cleared", 32'(bus.o_IRQ_PEND), 32'd0);

        // BRK hijacked by NMI
        bus.i_BRK = 1; tick(); bus.i_BRK = 0; #1;
        chk("brk_b", 32'(bus.o_B_FLAG), 32'd1);
        chk("brk_valid", 32'(bus.o_ID_VALID), 32'd0);
        chk("brk_vec_l", 32'(bus.o_VEC_L), 32'hFFFE);
        chk("brk_is_nmi", 32'(bus.o_IS_NMI), 32'd0);
        bus.i_NMI_N = 0; tick(); #1;
        chk("hijack_live_nmi", 32'(bus.o_IS_NMI), 32'd1);
        chk("hijack_live_vec", 32'(bus.o_VEC_L), 32'hFFFA);
        bus.i_VEC_LATCH = 1; tick(); bus.i_VEC_LATCH = 0; #1;
        chk("hijack_vec_l", 32'(bus.o_VEC_L), 32'hFFFA);
        chk("hijack_is_nmi", 32'(bus.o_IS_NMI), 32'd1);
        chk("hijack_b", 32'(bus.o_B_FLAG), 32'd1);
        bus.i_INT_DONE = 1; tick(); bus.i_INT_DONE = 0; bus.i_NMI_N = 1; #1;
        chk("hijack_idle_b", 32'(bus.o_B_FLAG), 32'd0);
        chk("hijack_idle_req", 32'(bus.o_INT_REQ), 32'd0);

        // Pause across a latch strobe with an NMI edge inside the pause
        bus.i_BRK = 1; tick(); bus.i_BRK = 0;
        bus.i_PAUSE = 1; bus.i_VEC_LATCH = 1; bus.i_NMI_N = 0;
        tick(); #1;
        chk("pause_nmi_pend", 32'(bus.o_IS_NMI), 32'd1);
        tick(); tick();
        bus.i_PAUSE = 0; bus.i_VEC_LATCH = 0; #1;
        chk("pause_still_seq", 32'(bus.o_IS_NMI), 32'd1);
        chk("pause_b", 32'(bus.o_B_FLAG), 32'd1);
        chk("pause_live_vec", 32'(bus.o_VEC_L), 32'hFFFA);
        bus.i_VEC_LATCH = 1; tick(); bus.i_VEC_LATCH = 0; #1;
        chk("pause_lat_vec", 32'(bus.o_VEC_L), 32'hFFFA);
        chk("pause_lat_nmi", 32'(bus.o_IS_NMI), 32'd1);
        bus.i_INT_DONE = 1; tick(); bus.i_INT_DONE = 0; bus.i_NMI_N = 1; #1;
        chk("pause_done_req", 32'(bus.o_INT_REQ), 32'd0);

        // Async reset in the middle of a sequence
        bus.i_IRQ_N = 4'b1011;
        bus.i_BRK = 1; tick(); bus.i_BRK = 0; #1;
        chk("arst_pre_pend", 32'(bus.o_IRQ_PEND), 32'b0100);
        i_RST_N = 0; #1;
        chk("arst_rst_seq", 32'(bus.o_RST_SEQ), 32'd1);
        chk("arst_b", 32'(bus.o_B_FLAG), 32'd0);
        chk("arst_pend", 32'(bus.o_IRQ_PEND), 32'd0);
        chk("arst_vec_l", 32'(bus.o_VEC_L), 32'hFFFC);
        bus.i_IRQ_N = 4'hF; tick();
        i_RST_N = 1; tick(); #1;
        chk("arst_after_seq", 32'(bus.o_RST_SEQ), 32'd1);
        chk("arst_after_pend", 32'(bus.o_IRQ_PEND), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
